column_sequencer: RTL and testbench
===================================

Name: column_sequencer

Overview:
- Schedules per-column draw jobs into line_writer. Streams the five 32-bit descriptor words per column into line_writer's start/load interface.
- Tracks the two halves of line_writer's double-buffered line RAM: half 0 at addresses 0-239, half 1 at 240-479.
- Hands each completed column to the LCD blitter and blocks the writer from overwriting a half that is still being read.
- Sits between the raycaster's descriptor stream and line_writer/LCD blit.

Parameters:
- COLS, 320, columns per frame.
- COL_W, 9, column counter width; must satisfy 2^COL_W >= COLS.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- frame_start  in  1  one-cycle pulse; latches frame_pos, clears column counter
- frame_pos  in  32  posx[31:16], posy[15:0] (Q8.8)
- desc_valid  in  1  descriptor word valid
- desc_data  in  32  descriptor word
- desc_ready  out  1  word accepted this cycle
- lw_start  out  1  to line_writer start
- lw_load  out  32  to line_writer load
- lw_pos  out  32  to line_writer pos; held at latched frame_pos
- lw_rdy  in  1  from line_writer rdy
- lw_done  in  1  from line_writer done
- blit_req  out  1  a completed column is available
- blit_half  out  1  line RAM half holding that column
- blit_col  out  COL_W  screen column index
- blit_ack  in  1  blitter accepted the request
- blit_done  in  1  blitter finished reading the half named at the last ack
- busy  out  1  high when the state is not IDLE or any half is full
- frame_done  out  1  one-cycle pulse after the blit_done of column COLS-1

Behaviour:
- Reset values: all outputs 0; state IDLE; wr_half=0; full[1:0]=0; col=0; widx=0; pos register 0.
- Descriptor order per column:
  - word0 = draw_start[31:16] / draw_end[15:0]
  - word1 = scale[31:16] / tex_initial[7:0]
  - word2 = tex_x[22:16] / texid[7:0]
  - word3 = floor_x / floor_y
  - word4 = distwall[15:0]
- lw_load = desc_data combinationally. lw_start = desc_valid & (state==SEND) & gate. desc_ready = lw_start.
- States:
  - IDLE: if col<COLS and full[wr_half]==0 -> SEND, widx=0. If col==COLS, stay in IDLE.
  - SEND, widx==0: gate=lw_rdy. Accepting word0 does widx=1.
  - SEND, widx 1..4: gate=1. Each acceptance does widx+1. Accepting word4 -> WAIT_DONE.
  - SEND stall: if desc_valid drops mid-column, lw_start is low and line_writer holds its LOAD state. No timeout.
  - WAIT_DONE: on lw_done, set full[wr_half]=1, queue {wr_half,col}, toggle wr_half, col+1 -> IDLE.
- wr_half must mirror line_writer's base toggle on every done. The writer and sequencer share rst, so both start at half 0.
- Blit queue:
  - Two entries, FIFO order.
  - blit_req = queue non-empty; blit_half/blit_col show the head entry.
  - blit_ack pops the head into an in-flight register. Only one blit is in flight at a time, and blit_req is masked while a blit is in flight.
  - blit_done clears full[inflight_half]. If inflight_col==COLS-1, frame_done pulses the next cycle.
- Same-cycle events:
  - lw_done and blit_done together: both updates apply.
  - A half freed by blit_done is usable for IDLE->SEND the next cycle.
- Writer-ahead limit: the writer can be at most two columns ahead of the blitter. With both halves full, stay in IDLE.
- frame_start:
  - Honoured only when state==IDLE and the queue and in-flight slot are empty; otherwise ignored.
  - Sets col=0 and latches pos. Blit column numbering restarts at 0.
  - col==COLS with no frame_start: idle until one arrives.
- Spurious inputs: lw_done outside WAIT_DONE is ignored. blit_done with nothing in flight is ignored.
- rst mid-column: returns to reset state in one cycle. Any partial descriptor is discarded. The upstream stream is responsible for restarting at word0.

Optional Feature:
- Macro COLSEQ_PERF_EN.
- When defined, add outputs stall_cycles[31:0] and wait_cycles[31:0]:
  - stall_cycles counts cycles in IDLE blocked by full[wr_half] while col<COLS.
  - wait_cycles counts cycles in SEND with desc_valid low.
  - Both clear on rst and on an accepted frame_start, and saturate at all-ones.
- When undefined, these ports and counters are absent; all other behaviour is identical.

Test Plan:
- Single column, COLS=320: after frame_start with pos=0x0A000B00, stream 5 words with desc_valid constantly high -> word0 is sent only when lw_rdy=1, then 5 consecutive lw_start cycles with lw_load equal to each word in order, lw_pos=0x0A000B00; after lw_done -> blit_req=1, blit_half=0, blit_col=0.
- Mid-column gap: desc_valid low for 3 cycles after word2 -> lw_start low for those 3 cycles, widx held, remaining words delivered in order.
- Backpressure: blitter never acks; three columns offered -> columns 0 and 1 complete; third stays in IDLE with lw_start=0. Ack plus blit_done of column 0 -> third column starts writing half 0.
- Simultaneous events: lw_done for column 1 and blit_done for column 0 in the same cycle -> full=2'b10, queue holds {1,1}, no lost update.
- Frame end, COLS=4: four columns completed and blitted -> frame_done pulses once after blit_done of col 3. Further descriptors are not accepted until the next frame_start.
- Reset in SEND after word1 -> next cycle all outputs 0, state IDLE; a fresh frame_start and full column complete normally to half 0.

Source files
------------

// File: rtl/column_sequencer.sv
// Column scheduler between the raycaster descriptor stream, line_writer and the LCD blitter.
// Optional perf counters (stall_cycles, wait_cycles) are built when COLSEQ_PERF_EN is defined.
module column_sequencer #(
    parameter int COLS  = 320,
    parameter int COL_W = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             frame_start,
    input  logic [31:0]      frame_pos,
    input  logic             desc_valid,
    input  logic [31:0]      desc_data,
    output logic             desc_ready,
    output logic             lw_start,
    output logic [31:0]      lw_load,
    output logic [31:0]      lw_pos,
    input  logic             lw_rdy,
    input  logic             lw_done,
    output logic             blit_req,
    output logic             blit_half,
    output logic [COL_W-1:0] blit_col,
    input  logic             blit_ack,
    input  logic             blit_done,
`ifdef COLSEQ_PERF_EN
    output logic [31:0]      stall_cycles,
    output logic [31:0]      wait_cycles,
`endif
    output logic             busy,
    output logic             frame_done
);

    typedef enum logic [1:0] {IDLE, SEND, WAIT_DONE} state_t;

    // Column counter is one bit wider so it can hold COLS itself (end of frame).
    localparam logic [COL_W:0]   COLS_V   = (COL_W + 1)'(COLS);
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLS - 1);

    state_t                  state;
    logic [2:0]              widx;
    logic                    wr_half;
    logic [1:0]              full;
    logic [COL_W:0]          col;
    logic [31:0]             pos;
    logic [1:0]              q_valid;
    logic [1:0]              q_half;
    logic [1:0][COL_W-1:0]   q_col;
    logic                    inflight_valid;
    logic                    inflight_half;
    logic [COL_W-1:0]        inflight_col;

    logic                    gate;
    logic                    frame_ok;
    logic                    wr_done;
    logic                    pop;
    logic                    free_half;
    logic                    push_slot;
    logic [1:0]              set_mask;
    logic [1:0]              clr_mask;

    always_comb begin
        gate      = (widx == 3'd0) ? lw_rdy : 1'b1;
        lw_start  = desc_valid && (state == SEND) && gate;
        desc_ready = lw_start;
        lw_load   = desc_data;
        lw_pos    = pos;
        blit_req  = q_valid[0] && !inflight_valid;
        blit_half = q_half[0];
        blit_col  = q_col[0];
        busy      = (state != IDLE) || (|full);
        frame_ok  = frame_start && (state == IDLE) && !q_valid[0] && !inflight_valid;
        wr_done   = (state == WAIT_DONE) && lw_done;
        pop       = blit_req && blit_ack;
        free_half = blit_done && inflight_valid;
        // After a pop the queue shifts down, so the free slot moves with it.
        push_slot = pop ? q_valid[1] : q_valid[0];
        set_mask  = wr_done   ? (2'b01 << wr_half)       : 2'b00;
        clr_mask  = free_half ? (2'b01 << inflight_half) : 2'b00;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            widx           <= 3'd0;
            wr_half        <= 1'b0;
            full           <= 2'b00;
            col            <= '0;
            pos            <= 32'd0;
            q_valid        <= 2'b00;
            q_half         <= 2'b00;
            q_col          <= '0;
            inflight_valid <= 1'b0;
            inflight_half  <= 1'b0;
            inflight_col   <= '0;
            frame_done     <= 1'b0;
        end else begin
            frame_done <= free_half && (inflight_col == LAST_COL);
            full       <= (full & ~clr_mask) | set_mask;

            case (state)
                IDLE: begin
                    if (frame_ok) begin
                        col <= '0;
                        pos <= frame_pos;
                    end
                    if ((col < COLS_V) && !full[wr_half]) begin
                        state <= SEND;
                        widx  <= 3'd0;
                    end
                end
                SEND: begin
                    if (lw_start) begin
                        if (widx == 3'd4) begin
                            state <= WAIT_DONE;
                            widx  <= 3'd0;
                        end else begin
                            widx <= widx + 3'd1;
                        end
                    end
                end
                WAIT_DONE: begin
                    if (lw_done) begin
                        wr_half <= ~wr_half;
                        col     <= col + 1'b1;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            if (pop) begin
                q_valid        <= {1'b0, q_valid[1]};
                q_half[0]      <= q_half[1];
                q_col[0]       <= q_col[1];
                inflight_valid <= 1'b1;
                inflight_half  <= q_half[0];
                inflight_col   <= q_col[0];
            end else if (free_half) begin
                inflight_valid <= 1'b0;
            end

            if (wr_done) begin
                q_valid[push_slot] <= 1'b1;
                q_half[push_slot]  <= wr_half;
                q_col[push_slot]   <= col[COL_W-1:0];
            end
        end
    end

`ifdef COLSEQ_PERF_EN
    // Saturating counters of writer stalls on a full half and upstream starvation.
    always_ff @(posedge clk) begin
        if (rst || frame_ok) begin
            stall_cycles <= 32'd0;
            wait_cycles  <= 32'd0;
        end else begin
            if ((state == IDLE) && (col < COLS_V) && full[wr_half] && (stall_cycles != 32'hFFFF_FFFF))
                stall_cycles <= stall_cycles + 32'd1;
            if ((state == SEND) && !desc_valid && (wait_cycles != 32'hFFFF_FFFF))
                wait_cycles <= wait_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_column_sequencer.sv
// Scoreboard bench for column_sequencer, built with a 4-column frame so frame end is reachable.
module tb_column_sequencer;

    localparam int COLS  = 4;
    localparam int COL_W = 3;

    logic             clk;
    logic             rst;
    logic             frame_start;
    logic [31:0]      frame_pos;
    logic             desc_valid;
    logic [31:0]      desc_data;
    logic             desc_ready;
    logic             lw_start;
    logic [31:0]      lw_load;
    logic [31:0]      lw_pos;
    logic             lw_rdy;
    logic             lw_done;
    logic             blit_req;
    logic             blit_half;
    logic [COL_W-1:0] blit_col;
    logic             blit_ack;
    logic             blit_done;
    logic             busy;
    logic             frame_done;

    column_sequencer #(.COLS(COLS), .COL_W(COL_W)) dut (
        .clk(clk), .rst(rst), .frame_start(frame_start), .frame_pos(frame_pos),
        .desc_valid(desc_valid), .desc_data(desc_data), .desc_ready(desc_ready),
        .lw_start(lw_start), .lw_load(lw_load), .lw_pos(lw_pos),
        .lw_rdy(lw_rdy), .lw_done(lw_done),
        .blit_req(blit_req), .blit_half(blit_half), .blit_col(blit_col),
        .blit_ack(blit_ack), .blit_done(blit_done),
        .busy(busy), .frame_done(frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;
    logic [31:0]    exp_words[$];
    logic [COL_W:0] exp_blit[$];
    logic           exp_half;
    int             exp_col;
    logic [31:0]    exp_pos;
    logic [COL_W-1:0] inflight_col;

    // Streams nwords descriptor words; optional gap of gap_len idle cycles once k==gap_after.
    task automatic stream_column(input logic [31:0] base, input int nwords, input int gap_after,
                                 input int gap_len, input int rdy_delay);
        int k = 0;
        int gap_left = gap_len;
        int cyc = 0;
        int first = -1;
        int last = -1;
        logic in_gap;
        logic [31:0] exp_w;
        for (int i = 0; i < nwords; i++) exp_words.push_back(base + 32'(i));
        while (k < nwords) begin
            lw_rdy = (cyc >= rdy_delay);
            if (k == gap_after && gap_left > 0) begin
                desc_valid = 1'b0;
                in_gap = 1'b1;
                gap_left--;
            end else begin
                desc_valid = 1'b1;
                desc_data = base + 32'(k);
                in_gap = 1'b0;
            end
            #1;
            if (in_gap) begin
                checks++;
                if (lw_start !== 1'b0) $display("[TB] FAIL gap_stall: lw_start=%b expected 0", lw_start);
                else passed++;
            end
            if (desc_valid && k == 0 && !lw_rdy) begin
                checks++;
                if (lw_start !== 1'b0) $display("[TB] FAIL word0_rdy_gate: lw_start=%b expected 0", lw_start);
                else passed++;
            end
            if (lw_start) begin
                exp_w = exp_words.pop_front();
                checks++;
                if (lw_load !== exp_w) $display("[TB] FAIL lw_load: got %h expected %h", lw_load, exp_w);
                else passed++;
                checks++;
                if (desc_ready !== 1'b1 || lw_pos !== exp_pos)
                    $display("[TB] FAIL lw_pos_ready: pos=%h ready=%b expected %h 1", lw_pos, desc_ready, exp_pos);
                else passed++;
                if (first < 0) first = cyc;
                last = cyc;
                k++;
            end
            cyc++;
            @(negedge clk);
            if (cyc > 200) begin
                checks++;
                $display("[TB] FAIL stream_timeout: words sent %0d expected %0d", k, nwords);
                exp_words.delete();
                break;
            end
        end
        desc_valid = 1'b0;
        if (gap_len == 0 && nwords == 5 && k == 5) begin
            checks++;
            if (last - first != 4) $display("[TB] FAIL consecutive: span %0d expected 4", last - first);
            else passed++;
        end
    endtask

    task automatic complete_column(input logic with_blit_done);
        lw_done = 1'b1;
        blit_done = with_blit_done;
        exp_blit.push_back({exp_half, COL_W'(exp_col)});
        exp_half = ~exp_half;
        exp_col++;
        @(negedge clk);
        lw_done = 1'b0;
        blit_done = 1'b0;
    endtask

    task automatic do_ack();
        int waited = 0;
        logic [COL_W:0] e;
        #1;
        while (!blit_req && waited < 20) begin
            @(negedge clk);
            #1;
            waited++;
        end
        checks++;
        if (!blit_req || exp_blit.size() == 0) begin
            $display("[TB] FAIL blit_req_wait: req=%b queued=%0d expected req 1", blit_req, exp_blit.size());
            return;
        end
        passed++;
        e = exp_blit.pop_front();
        checks++;
        if (blit_half !== e[COL_W] || blit_col !== e[COL_W-1:0])
            $display("[TB] FAIL blit_head: half=%b col=%0d expected %b %0d", blit_half, blit_col, e[COL_W], e[COL_W-1:0]);
        else passed++;
        inflight_col = e[COL_W-1:0];
        blit_ack = 1'b1;
        @(negedge clk);
        blit_ack = 1'b0;
        #1;
        checks++;
        if (blit_req !== 1'b0) $display("[TB] FAIL req_masked: blit_req=%b expected 0", blit_req);
        else passed++;
    endtask

    task automatic do_done();
        logic exp_fd;
        exp_fd = (inflight_col == COL_W'(COLS - 1));
        blit_done = 1'b1;
        @(negedge clk);
        blit_done = 1'b0;
        #1;
        checks++;
        if (frame_done !== exp_fd) $display("[TB] FAIL frame_done_pulse: got %b expected %b", frame_done, exp_fd);
        else passed++;
        @(negedge clk);
        #1;
        checks++;
        if (frame_done !== 1'b0) $display("[TB] FAIL frame_done_single: got %b expected 0", frame_done);
        else passed++;
    endtask

    task automatic test_blocked(input int n);
        for (int i = 0; i < n; i++) begin
            desc_valid = 1'b1;
            desc_data = 32'hDEAD_0000 + 32'(i);
            lw_rdy = 1'b1;
            #1;
            checks++;
            if (lw_start !== 1'b0) $display("[TB] FAIL blocked_start: lw_start=%b expected 0", lw_start);
            else passed++;
            @(negedge clk);
        end
        desc_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1;
        checks++;
        if ({lw_start, desc_ready, blit_req, blit_half, blit_col, busy, frame_done} !== '0 || lw_pos !== 32'd0)
            $display("[TB] FAIL reset_outputs: start=%b req=%b busy=%b fd=%b pos=%h expected all 0",
                     lw_start, blit_req, busy, frame_done, lw_pos);
        else passed++;
        rst = 1'b0;
        frame_start = 1'b1;
        frame_pos = 32'h0A00_0B00;
        exp_pos = 32'h0A00_0B00;
        exp_half = 1'b0;
        exp_col = 0;
        @(negedge clk);
        frame_start = 1'b0;
    endtask

    task automatic test_single_column();
        stream_column(32'h1111_0000, 5, -1, 0, 3);
        complete_column(1'b0);
        #1;
        checks++;
        if (blit_req !== 1'b1 || blit_half !== 1'b0 || blit_col !== 3'd0)
            $display("[TB] FAIL single_blit: req=%b half=%b col=%0d expected 1 0 0", blit_req, blit_half, blit_col);
        else passed++;
    endtask

    task automatic test_gap();
        stream_column(32'h2222_0000, 5, 3, 3, 0);
        complete_column(1'b0);
    endtask

    task automatic test_backpressure();
        test_blocked(8);
        #1;
        checks++;
        if (busy !== 1'b1) $display("[TB] FAIL blocked_busy: busy=%b expected 1", busy);
        else passed++;
        do_ack();
        do_done();
        stream_column(32'h3333_0000, 5, -1, 0, 0);
        complete_column(1'b0);
    endtask

    task automatic test_simultaneous_and_frame_end();
        do_ack();
        do_done();
        do_ack();
        stream_column(32'h4444_0000, 5, -1, 0, 0);
        complete_column(1'b1);
        #1;
        checks++;
        if (busy !== 1'b1 || blit_req !== 1'b1) $display("[TB] FAIL simul_state: busy=%b req=%b expected 1 1", busy, blit_req);
        else passed++;
        do_ack();
        do_done();
        checks++;
        if (busy !== 1'b0) $display("[TB] FAIL frame_end_idle: busy=%b expected 0", busy);
        else passed++;
        test_blocked(8);
    endtask

    task automatic test_reset_mid_column();
        frame_start = 1'b1;
        frame_pos = 32'h0100_0200;
        exp_pos = 32'h0100_0200;
        exp_col = 0;
        @(negedge clk);
        frame_start = 1'b0;
        stream_column(32'h5555_0000, 2, -1, 0, 0);
        rst = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if ({lw_start, desc_ready, blit_req, busy, frame_done} !== 5'b0 || lw_pos !== 32'd0)
            $display("[TB] FAIL mid_reset: start=%b req=%b busy=%b pos=%h expected all 0", lw_start, blit_req, busy, lw_pos);
        else passed++;
        rst = 1'b0;
        frame_start = 1'b1;
        frame_pos = 32'h0300_0400;
        exp_pos = 32'h0300_0400;
        exp_words.delete();
        exp_blit.delete();
        exp_half = 1'b0;
        exp_col = 0;
        @(negedge clk);
        frame_start = 1'b0;
        stream_column(32'h6666_0000, 5, -1, 0, 1);
        complete_column(1'b0);
        do_ack();
        do_done();
    endtask

    initial begin
        rst = 1'b1; frame_start = 1'b0; frame_pos = 32'd0;
        desc_valid = 1'b0; desc_data = 32'd0; lw_rdy = 1'b0; lw_done = 1'b0;
        blit_ack = 1'b0; blit_done = 1'b0;
        exp_half = 1'b0; exp_col = 0; exp_pos = 32'd0; inflight_col = '0;
        test_reset();
        test_single_column();
        test_gap();
        test_backpressure();
        test_simultaneous_and_frame_end();
        test_reset_mid_column();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
